// File: rtl/port_encode_pkg.sv
// Shared I/O map for port_encode: port address defaults,
// vector format and interrupt state encodings.
package port_encode_pkg;

  localparam logic [7:0] BASE_PORT_DEF = 8'h00;
  localparam logic [7:0] VEC_PORT_DEF  = 8'h10;
  localparam logic [7:0] MASK_PORT_DEF = 8'h11;
  localparam logic [7:0] PEND_PORT_DEF = 8'h12;

  localparam logic [4:0] VEC_HI = 5'b1_0000;

  typedef enum logic {
    IDLE       = 1'b0,
    IN_SERVICE = 1'b1
  } state_t;

endpackage

// File: rtl/port_encode_prio_enc.sv
// Lowest-index-first priority encoder for the
// masked pending interrupt bits.
module irq_prio_enc (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = 3'd0;
    any = |req;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/port_encode.sv
// Port-mapped read mux plus an 8-source interrupt
// controller with a vector register and enable mask.
module port_encode
  import port_encode_pkg::*;
#(
  parameter logic [7:0] BASE_PORT = BASE_PORT_DEF,
  parameter logic [7:0] VEC_PORT  = VEC_PORT_DEF,
  parameter logic [7:0] MASK_PORT = MASK_PORT_DEF,
  parameter logic [7:0] PEND_PORT = PEND_PORT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  port_id,
  input  logic        rd_strobe,
  input  logic        wr_strobe,
  input  logic [7:0]  out_port,
  input  logic [63:0] src_data,
  input  logic [7:0]  irq_req,
  input  logic        interrupt_ack,
  output logic [7:0]  in_port,
  output logic        interrupt
);

  state_t     state;
  logic [7:0] mask;
  logic [7:0] pending;
  logic [7:0] vector;
  logic [7:0] masked;
  logic [2:0] idx;
  logic       any;
  logic [7:0] off;
  logic [7:0] rd_sel;
  logic       vec_rd;
  logic [7:0] clr;

  assign masked = pending & mask;
  assign off    = port_id - BASE_PORT;
  assign vec_rd = rd_strobe && (port_id == VEC_PORT);
  assign clr    = (state == IN_SERVICE && vec_rd)
                ? (8'b1 << vector[2:0]) : 8'h00;

  irq_prio_enc u_enc (
    .req (masked),
    .idx (idx),
    .any (any)
  );

  always_comb begin
    rd_sel = 8'h00;
    if (port_id == VEC_PORT)
      rd_sel = vector;
    else if (port_id == MASK_PORT)
      rd_sel = mask;
    else if (port_id == PEND_PORT)
      rd_sel = pending;
    else if (off[7:3] == 5'd0)
      rd_sel = src_data[{off[2:0], 3'b000} +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mask      <= 8'h00;
      pending   <= 8'h00;
      vector    <= 8'h00;
      in_port   <= 8'h00;
      interrupt <= 1'b0;
    end else begin
      in_port <= rd_sel;
      if (wr_strobe && port_id == MASK_PORT)
        mask <= out_port;
      // a new request beats the acknowledge-read clear
      pending <= (pending & ~clr) | irq_req;
      unique case (state)
        IDLE: begin
          if (interrupt_ack) begin
            vector <= any ? {VEC_HI, idx} : 8'h00;
          end
          if (interrupt_ack && any) begin
            state     <= IN_SERVICE;
            interrupt <= 1'b0;
          end else begin
            interrupt <= any;
          end
        end
        IN_SERVICE: begin
          interrupt <= 1'b0;
          if (vec_rd) begin
            vector <= 8'h00;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_encode.sv
// Directed sequences plus random traffic for port_encode,
// checked each cycle against a behavioural model.
module tb_port_encode;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  port_id;
  logic        rd_strobe;
  logic        wr_strobe;
  logic [7:0]  out_port;
  logic [63:0] src_data;
  logic [7:0]  irq_req;
  logic        interrupt_ack;
  logic [7:0]  in_port;
  logic        interrupt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] m_mask, m_pend, m_vec, m_in;
  bit         m_insvc, m_int;

  always #5 clk = ~clk;

  port_encode dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .rd_strobe     (rd_strobe),
    .wr_strobe     (wr_strobe),
    .out_port      (out_port),
    .src_data      (src_data),
    .irq_req       (irq_req),
    .interrupt_ack (interrupt_ack),
    .in_port       (in_port),
    .interrupt     (interrupt)
  );

  function automatic logic [7:0] m_read(input logic [7:0] p);
    int n;
    if (p == 8'h10) return m_vec;
    if (p == 8'h11) return m_mask;
    if (p == 8'h12) return m_pend;
    if (p < 8) begin
      n = p;
      return src_data[n*8 +: 8];
    end
    return 8'h00;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock, update the model, compare outputs.
  task automatic step();
    logic [7:0] nin, hits, npend, nvec, nmask;
    bit nint, nsvc;
    int low;
    nin   = m_read(port_id);
    hits  = m_pend & m_mask;
    low   = -1;
    for (int i = 0; i < 8; i++)
      if (hits[i] && low < 0) low = i;
    npend = m_pend;
    nvec  = m_vec;
    nsvc  = m_insvc;
    nint  = 1'b0;
    if (!m_insvc) begin
      if (interrupt_ack) nvec = (low < 0) ? 8'h00 : 8'(8'h80 + low);
      if (interrupt_ack && low >= 0) nsvc = 1'b1;
      else nint = (hits != 0);
    end else if (rd_strobe && port_id == 8'h10) begin
      npend[m_vec % 8] = 1'b0;
      nvec = 8'h00;
      nsvc = 1'b0;
    end
    npend = npend | irq_req;
    nmask = (wr_strobe && port_id == 8'h11) ? out_port : m_mask;
    if (reset) begin
      nin = 0; nint = 0; nmask = 0; npend = 0; nvec = 0; nsvc = 0;
    end
    @(posedge clk);
    #1;
    m_in = nin; m_int = nint; m_mask = nmask;
    m_pend = npend; m_vec = nvec; m_insvc = nsvc;
    chk("in_port", in_port, m_in);
    chk("interrupt", {7'b0, interrupt}, {7'b0, m_int});
  endtask

  task automatic quiet();
    reset = 0; port_id = 8'h40; rd_strobe = 0; wr_strobe = 0;
    out_port = 0; irq_req = 0; interrupt_ack = 0;
  endtask

  initial begin
    quiet();
    src_data = 64'h0706_0504_0302_0100;
    reset = 1;
    m_mask = 0; m_pend = 0; m_vec = 0; m_in = 0;
    m_insvc = 0; m_int = 0;
    step(); step();
    chk("rst_in_port", in_port, 8'h00);
    quiet();

    // source read and unmapped port
    src_data[31:24] = 8'hA5;
    port_id = 8'h03; step();
    chk("src3", in_port, 8'hA5);
    port_id = 8'h40; step();
    chk("unmapped", in_port, 8'h00);

    // two requests serviced lowest first
    port_id = 8'h11; wr_strobe = 1; out_port = 8'hFF; step(); quiet();
    irq_req = 8'b0010_0100; step(); quiet();
    step();
    chk("irq_up", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1; step(); quiet();
    chk("irq_ack_low", {7'b0, interrupt}, 8'h00);
    port_id = 8'h10; rd_strobe = 1; step(); quiet();
    chk("vec_82", in_port, 8'h82);
    port_id = 8'h12; step();
    chk("pend_20", in_port, 8'h20);
    chk("irq_again", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1; step(); quiet();
    port_id = 8'h10; step();
    chk("vec_85", in_port, 8'h85);
    rd_strobe = 1; step(); quiet();

    // masked pending then unmask
    port_id = 8'h11; wr_strobe = 1; out_port = 8'h00; step(); quiet();
    irq_req = 8'h02; step(); quiet();
    step();
    port_id = 8'h12; step();
    chk("pend_02", in_port, 8'h02);
    chk("masked_lo", {7'b0, interrupt}, 8'h00);
    port_id = 8'h11; wr_strobe = 1; out_port = 8'h02; step(); quiet();
    step();
    chk("unmask_hi", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1; step(); quiet();
    port_id = 8'h10; rd_strobe = 1; step(); quiet();

    // set wins over clear
    port_id = 8'h11; wr_strobe = 1; out_port = 8'hFF; step(); quiet();
    irq_req = 8'h04; step(); quiet();
    interrupt_ack = 1; step(); quiet();
    port_id = 8'h10; rd_strobe = 1; irq_req = 8'h04; step(); quiet();
    port_id = 8'h12; step();
    chk("pend_kept", in_port, 8'h04);
    chk("irq_reassert", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1; step(); quiet();
    port_id = 8'h10; rd_strobe = 1; step(); quiet();

    // reset mid-service
    irq_req = 8'h81; step(); quiet();
    interrupt_ack = 1; step(); quiet();
    reset = 1; step(); step(); quiet();
    chk("rst_int", {7'b0, interrupt}, 8'h00);
    port_id = 8'h12; step();
    chk("rst_pend", in_port, 8'h00);
    interrupt_ack = 1; port_id = 8'h40; step(); quiet();
    port_id = 8'h10; step();
    chk("ack_empty", in_port, 8'h00);
    chk("ack_empty_int", {7'b0, interrupt}, 8'h00);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      quiet();
      case ($urandom_range(0, 3))
        0: port_id = 8'($urandom_range(0, 7));
        1: port_id = 8'($urandom_range(16, 18));
        2: port_id = 8'h10;
        default: port_id = 8'($urandom);
      endcase
      src_data      = {$urandom, $urandom};
      rd_strobe     = ($urandom_range(0, 2) == 0);
      wr_strobe     = ($urandom_range(0, 5) == 0);
      out_port      = 8'($urandom);
      irq_req       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      interrupt_ack = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/port_encode.md
PORT_ENCODE -- requirements
Module: port_encode

Interface
REQ-001 SHALL have parameter BASE_PORT, default 8'h00: port_id of data source 0; source i maps to BASE_PORT+i, i=0..7.
REQ-002 SHALL have parameter VEC_PORT, default 8'h10: read-only interrupt vector register.
REQ-003 SHALL have parameter MASK_PORT, default 8'h11: read/write interrupt enable mask.
REQ-004 SHALL have parameter PEND_PORT, default 8'h12: read-only pending-interrupt register.
REQ-005 SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port port_id, input, 8: processor port address.
REQ-008 SHALL have port rd_strobe, input, 1: processor read strobe.
REQ-009 SHALL have port wr_strobe, input, 1: processor write strobe.
REQ-010 SHALL have port out_port, input, 8: processor write data.
REQ-011 SHALL have port src_data, input, 64: eight 8-bit peripheral read values; source i at bits [8i+7:8i].
REQ-012 SHALL have port irq_req, input, 8: per-source interrupt request pulses, one clk wide.
REQ-013 SHALL have port interrupt_ack, input, 1: processor interrupt acknowledge pulse.
REQ-014 SHALL have port in_port, output, 8: registered read data to the processor.
REQ-015 SHALL have port interrupt, output, 1: registered interrupt request to the processor.

Function
REQ-016 in_port SHALL update every cycle with the value selected by the port_id sampled in the previous cycle; latency is exactly 1 clk.
REQ-017 Read selection SHALL be: src_data byte i for BASE_PORT+i; vector for VEC_PORT; mask for MASK_PORT; pending for PEND_PORT; 8'h00 for any unmapped port.
REQ-018 If ports overlap, precedence SHALL be VEC_PORT > MASK_PORT > PEND_PORT > source map.
REQ-019 When wr_strobe=1 and port_id=MASK_PORT, mask SHALL load out_port on that edge; writes to any other port SHALL be ignored.
REQ-020 On a cycle with irq_req[i]=1, pending[i] SHALL set on that edge, regardless of mask.
REQ-021 The state machine SHALL have two states: IDLE and IN_SERVICE.
REQ-022 In IDLE, interrupt SHALL be registered as |(pending & mask); in IN_SERVICE, interrupt SHALL be 0.
REQ-023 interrupt_ack in IDLE SHALL latch the vector from the (pending & mask) value present on that edge, then move to IN_SERVICE.
REQ-024 Vector encoding SHALL be {1'b1, 4'b0, idx[2:0]}, where idx is the lowest set bit.
REQ-025 If interrupt_ack arrives in IDLE with (pending & mask)==0, vector SHALL load 8'h00 and the state SHALL remain IDLE.
REQ-026 interrupt_ack in IN_SERVICE SHALL be ignored.
REQ-027 rd_strobe with port_id=VEC_PORT in IN_SERVICE SHALL clear pending[idx], clear vector to 8'h00 and return to IDLE, all on the same edge.
REQ-028 rd_strobe with port_id=VEC_PORT in IDLE SHALL have no side effects.
REQ-029 If irq_req[idx] and the clearing read occur on the same edge, pending[idx] SHALL remain set (set wins).
REQ-030 Reading PEND_PORT or MASK_PORT SHALL have no side effects.
REQ-031 Masked pending bits SHALL be retained and SHALL raise interrupt once unmasked, with interrupt registered 1 clk after the mask write.

Reset
REQ-032 While reset=1, in_port, interrupt, mask, pending and vector SHALL be 8'h00/0 and the state SHALL be IDLE.
REQ-033 Reset asserted mid-service SHALL abandon the in-service interrupt; a new irq_req arriving after reset deasserts SHALL be serviced normally.

Structure
REQ-034 The port address constants (BASE_PORT, VEC_PORT, MASK_PORT, PEND_PORT defaults) and the state encodings SHALL live in the shared I/O-map include.
REQ-035 The lowest-index priority encoder SHALL be a combinational sub-module irq_prio_enc: 8-bit input; 3-bit index and any-valid flag outputs.

Verification
REQ-036 Sequence 1: src_data byte 3=8'hA5, port_id=8'h03 -> in_port=8'hA5 on the next edge; port_id=8'h40 -> in_port=8'h00.
REQ-037 Sequence 2: write 8'hFF to 8'h11, pulse irq_req=8'b0010_0100 -> interrupt=1; ack -> interrupt=0, vector=8'h82; read 8'h10 -> pending=8'h20; interrupt re-asserts; ack -> vector=8'h85.
REQ-038 Sequence 3: mask=8'h00, pulse irq_req[1] -> interrupt stays 0, PEND_PORT reads 8'h02; write mask 8'h02 -> interrupt=1 one clk later.
REQ-039 Sequence 4: with idx=2 in service, irq_req[2] on the same edge as the VEC_PORT read -> pending[2] stays 1 and interrupt re-asserts.
REQ-040 Sequence 5: reset asserted while IN_SERVICE with pending=8'h81 -> all outputs 0 and pending=8'h00; after release, ack with nothing pending -> vector=8'h00, interrupt stays 0.
